// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: one shared period counter, double-buffered period and pulsewidths.
// Optional macro SERVO_PWM_POLARITY_EN adds a per-channel output polarity input (pol).
module servo_pwm_multi #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned AW       = $clog2(CHANNELS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
`ifdef SERVO_PWM_POLARITY_EN
   input  logic [CHANNELS-1:0] pol,
`endif
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_end,
   output logic                upd_pending
);

   logic [WIDTH-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]    act_period_q, act_period_d;
   logic [WIDTH-1:0]    shd_period_q, shd_period_d;
   logic [WIDTH-1:0]    act_pw_q [CHANNELS];
   logic [WIDTH-1:0]    act_pw_d [CHANNELS];
   logic [WIDTH-1:0]    shd_pw_q [CHANNELS];
   logic [WIDTH-1:0]    shd_pw_d [CHANNELS];
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic                period_end_q, period_end_d;
   logic                upd_pending_q, upd_pending_d;
   logic                wrap;
   logic                wr_valid;
   logic                cmp;

   always_comb begin
      wrap     = en & (cnt_q == act_period_q);
      wr_valid = wr_en & (wr_addr <= AW'(CHANNELS));

      cnt_d = (!en || wrap) ? '0 : cnt_q + 1'b1;

      // Active registers sample the shadows before this cycle's write lands,
      // so a write coinciding with a wrap takes effect one period later.
      shd_period_d = shd_period_q;
      act_period_d = act_period_q;
      if (wr_valid && (wr_addr == AW'(CHANNELS))) shd_period_d = wr_data;
      if (!en || wrap) act_period_d = shd_period_q;

      pwm_d = '0;
      cmp   = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         shd_pw_d[i] = shd_pw_q[i];
         act_pw_d[i] = act_pw_q[i];
         if (wr_valid && (wr_addr == AW'(i))) shd_pw_d[i] = wr_data;
         if (!en || wrap) act_pw_d[i] = shd_pw_q[i];
         cmp = (cnt_q < act_pw_q[i]);
`ifdef SERVO_PWM_POLARITY_EN
         pwm_d[i] = en ? (cmp ^ pol[i]) : pol[i];
`else
         pwm_d[i] = en & cmp;
`endif
      end

      period_end_d  = wrap;
      upd_pending_d = en & (wr_valid | (upd_pending_q & ~wrap));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         act_period_q  <= '1;
         shd_period_q  <= '1;
         pwm_q         <= '0;
         period_end_q  <= 1'b0;
         upd_pending_q <= 1'b0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            act_pw_q[i] <= '0;
            shd_pw_q[i] <= '0;
         end
      end else begin
         cnt_q         <= cnt_d;
         act_period_q  <= act_period_d;
         shd_period_q  <= shd_period_d;
         pwm_q         <= pwm_d;
         period_end_q  <= period_end_d;
         upd_pending_q <= upd_pending_d;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            act_pw_q[i] <= act_pw_d[i];
            shd_pw_q[i] <= shd_pw_d[i];
         end
      end
   end

   assign pwm_out     = pwm_q;
   assign period_end  = period_end_q;
   assign upd_pending = upd_pending_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: directed test-plan scenarios plus randomized traffic
// checked against a period/config-level reference model.
module tb_servo_pwm_multi;
   localparam int W  = 16;
   localparam int CH = 4;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
`ifdef SERVO_PWM_POLARITY_EN
   logic [CH-1:0] pol = '0;
`endif
   logic [CH-1:0] pwm_out;
   logic          period_end;
   logic          upd_pending;

   int vectors = 0;
   int miscompares = 0;

   // reference model: current configuration, pending configuration, position in period
   int            m_pos, m_per, m_next_per;
   int            m_pw [CH];
   int            m_next_pw [CH];
   logic [CH-1:0] m_pwm;
   logic          m_pe, m_pend;

   servo_pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SERVO_PWM_POLARITY_EN
      .pol(pol),
`endif
      .pwm_out(pwm_out), .period_end(period_end), .upd_pending(upd_pending)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      logic last;
      logic c;
      bit   wv;
      if (rst) begin
         m_pos = 0; m_per = 65535; m_next_per = 65535;
         for (int i = 0; i < CH; i++) begin m_pw[i] = 0; m_next_pw[i] = 0; end
         m_pwm = '0; m_pe = 1'b0; m_pend = 1'b0;
         return;
      end
      last = en && (m_pos == m_per);
      for (int i = 0; i < CH; i++) begin
         c = (m_pos < m_pw[i]);
`ifdef SERVO_PWM_POLARITY_EN
         m_pwm[i] = en ? (c ^ pol[i]) : pol[i];
`else
         m_pwm[i] = en && c;
`endif
      end
      m_pe = last;
      if (!en || last) begin
         m_pos = 0; m_per = m_next_per; m_pw = m_next_pw;
      end else begin
         m_pos = m_pos + 1;
      end
      wv = wr_en && (int'(wr_addr) <= CH);
      if (wv) begin
         if (int'(wr_addr) == CH) m_next_per = int'(wr_data);
         else m_next_pw[wr_addr] = int'(wr_data);
      end
      m_pend = en && (wv || (m_pend && !last));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      tick(); tick();
      vectors++;
      if ({pwm_out, period_end, upd_pending} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b required %b", {pwm_out, period_end, upd_pending}, 6'b0);
      end
      rst = 1'b0;
      tick();
      vectors++;
      if ({pwm_out, period_end, upd_pending} !== {m_pwm, m_pe, m_pend}) begin
         miscompares++;
         $display("FAIL reset_release: got %b required %b", {pwm_out, period_end, upd_pending}, {m_pwm, m_pe, m_pend});
      end
   endtask

   task automatic test_run();
      int addrs [3] = '{4, 0, 1};
      int datas [3] = '{9, 3, 2};
      int hi0 = 0, pe_n = 0, last_pe = -1;
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wr_en = (k < 3); wr_addr = AW'(addrs[k % 3]); wr_data = W'(datas[k % 3]);
         tick();
         vectors++;
         if ({pwm_out, period_end, upd_pending} !== {m_pwm, m_pe, m_pend}) begin
            miscompares++;
            $display("FAIL run_setup: got %b required %b", {pwm_out, period_end, upd_pending}, {m_pwm, m_pe, m_pend});
         end
      end
      wr_en = 1'b0;
      en = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         vectors++;
         if ({pwm_out, period_end, upd_pending} !== {m_pwm, m_pe, m_pend}) begin
            miscompares++;
            $display("FAIL run_cycle%0d: got %b required %b", k, {pwm_out, period_end, upd_pending}, {m_pwm, m_pe, m_pend});
         end
         if (k >= 10) begin
            hi0 += int'(pwm_out[0]);
            pe_n += int'(period_end);
            if (period_end) begin
               if (last_pe >= 0) begin
                  vectors++;
                  if (k - last_pe !== 10) begin
                     miscompares++;
                     $display("FAIL run_period_gap: got %0d required 10", k - last_pe);
                  end
               end
               last_pe = k;
            end
         end
      end
      vectors++;
      if (hi0 !== 6) begin miscompares++; $display("FAIL run_ch0_high: got %0d required 6", hi0); end
      vectors++;
      if (pe_n !== 2) begin miscompares++; $display("FAIL run_period_end_count: got %0d required 2", pe_n); end
   endtask

   task automatic test_glitch_free();
      int hi0 = 0, guard = 0;
      while (m_pos != 5 && guard < 20) begin tick(); guard++; end
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'd8;
      tick();
      wr_en = 1'b0;
      vectors++;
      if (upd_pending !== 1'b1) begin miscompares++; $display("FAIL glitch_pending_set: got %b required 1", upd_pending); end
      guard = 0;
      while (!period_end && guard < 20) begin
         vectors++;
         if (upd_pending !== 1'b1 || pwm_out[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_hold: pending %b ch0 %b required 1 0", upd_pending, pwm_out[0]);
         end
         tick(); guard++;
      end
      vectors++;
      if (!period_end || upd_pending !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_wrap: period_end %b pending %b required 1 0", period_end, upd_pending);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         hi0 += int'(pwm_out[0]);
         vectors++;
         if ({pwm_out, period_end, upd_pending} !== {m_pwm, m_pe, m_pend}) begin
            miscompares++;
            $display("FAIL glitch_cycle%0d: got %b required %b", k, {pwm_out, period_end, upd_pending}, {m_pwm, m_pe, m_pend});
         end
      end
      vectors++;
      if (hi0 !== 8) begin miscompares++; $display("FAIL glitch_new_width: got %0d required 8", hi0); end
   endtask

   task automatic test_write_on_wrap();
      int hi1a = 0, hi1b = 0, guard = 0;
      while (m_pos != 9 && guard < 20) begin tick(); guard++; end
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'd6;
      tick();
      wr_en = 1'b0;
      vectors++;
      if (period_end !== 1'b1 || upd_pending !== 1'b1) begin
         miscompares++;
         $display("FAIL wrapwr_edge: period_end %b pending %b required 1 1", period_end, upd_pending);
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         if (k < 10) hi1a += int'(pwm_out[1]); else hi1b += int'(pwm_out[1]);
         if (k < 9) begin
            vectors++;
            if (upd_pending !== 1'b1) begin miscompares++; $display("FAIL wrapwr_pending%0d: got %b required 1", k, upd_pending); end
         end
         vectors++;
         if ({pwm_out, period_end, upd_pending} !== {m_pwm, m_pe, m_pend}) begin
            miscompares++;
            $display("FAIL wrapwr_cycle%0d: got %b required %b", k, {pwm_out, period_end, upd_pending}, {m_pwm, m_pe, m_pend});
         end
      end
      vectors++;
      if (hi1a !== 2) begin miscompares++; $display("FAIL wrapwr_old_width: got %0d required 2", hi1a); end
      vectors++;
      if (hi1b !== 6) begin miscompares++; $display("FAIL wrapwr_new_width: got %0d required 6", hi1b); end
   endtask

   task automatic test_period_change();
      int n, guard = 0;
      while (m_pos != 3 && guard < 20) begin tick(); guard++; end
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'd4;
      tick();
      wr_en = 1'b0;
      for (int p = 0; p < 2; p++) begin
         n = 0;
         do begin
            tick(); n++;
            vectors++;
            if ({pwm_out, period_end, upd_pending} !== {m_pwm, m_pe, m_pend}) begin
               miscompares++;
               $display("FAIL perchg_cycle: got %b required %b", {pwm_out, period_end, upd_pending}, {m_pwm, m_pe, m_pend});
            end
         end while (!period_end && n < 20);
         vectors++;
         if (n !== (p == 0 ? 6 : 5)) begin
            miscompares++;
            $display("FAIL perchg_len%0d: got %0d required %0d", p, n, (p == 0 ? 6 : 5));
         end
      end
   endtask

   task automatic test_extremes();
      int addrs [3] = '{4, 2, 3};
      int datas [3] = '{9, 0, 10};
      int hi2 = 0, hi3 = 0, pe_n = 0;
      for (int k = 0; k < 3; k++) begin
         wr_en = 1'b1; wr_addr = AW'(addrs[k]); wr_data = W'(datas[k]);
         tick();
      end
      wr_en = 1'b0;
      for (int k = 0; k < 45; k++) begin
         tick();
         if (k >= 25) begin hi2 += int'(pwm_out[2]); hi3 += int'(pwm_out[3]); end
         vectors++;
         if ({pwm_out, period_end, upd_pending} !== {m_pwm, m_pe, m_pend}) begin
            miscompares++;
            $display("FAIL extreme_cycle%0d: got %b required %b", k, {pwm_out, period_end, upd_pending}, {m_pwm, m_pe, m_pend});
         end
      end
      vectors++;
      if (hi2 !== 0) begin miscompares++; $display("FAIL extreme_zero_width: got %0d high cycles required 0", hi2); end
      vectors++;
      if (hi3 !== 20) begin miscompares++; $display("FAIL extreme_full_width: got %0d high cycles required 20", hi3); end
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'd0;
      tick();
      wr_en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (k >= 15) pe_n += int'(period_end);
      end
      vectors++;
      if (pe_n !== 5) begin miscompares++; $display("FAIL extreme_period0: got %0d period_end pulses required 5", pe_n); end
   endtask

   task automatic test_reset_mid();
      int guard = 0, act = 0;
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'd9;
      tick();
      wr_en = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      while (m_pos != 2 && guard < 20) begin tick(); guard++; end
      rst = 1'b1;
      tick();
      vectors++;
      if ({pwm_out, period_end, upd_pending} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got %b required %b", {pwm_out, period_end, upd_pending}, 6'b0);
      end
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         act |= int'({pwm_out, period_end, upd_pending});
      end
      vectors++;
      if (act !== 0) begin miscompares++; $display("FAIL rstmid_cleared: got activity %b required 0", act[5:0]); end
   endtask

   task automatic test_random();
      en = 1'b1;
      for (int k = 0; k < 800; k++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 29) == 0) en = ~en;
         wr_en = ($urandom_range(0, 3) == 0);
         wr_addr = AW'($urandom_range(0, 7));
         wr_data = (wr_addr == 3'd4) ? W'($urandom_range(0, 12)) : W'($urandom_range(0, 14));
         tick();
         vectors++;
         if ({pwm_out, period_end, upd_pending} !== {m_pwm, m_pe, m_pend}) begin
            miscompares++;
            $display("FAIL random_cycle%0d: got %b required %b", k, {pwm_out, period_end, upd_pending}, {m_pwm, m_pe, m_pend});
         end
      end
      rst = 1'b0; wr_en = 1'b0;
   endtask

`ifdef SERVO_PWM_POLARITY_EN
   task automatic test_polarity();
      int hi0 = 0;
      rst = 1'b1; en = 1'b0; pol = 4'b0001;
      tick();
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'd9; tick();
      wr_addr = 3'd0; wr_data = 16'd3; tick();
      wr_en = 1'b0; tick();
      vectors++;
      if (pwm_out !== 4'b0001) begin miscompares++; $display("FAIL pol_idle: got %b required 0001", pwm_out); end
      en = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (k >= 10) hi0 += int'(pwm_out[0]);
         vectors++;
         if ({pwm_out, period_end, upd_pending} !== {m_pwm, m_pe, m_pend}) begin
            miscompares++;
            $display("FAIL pol_cycle%0d: got %b required %b", k, {pwm_out, period_end, upd_pending}, {m_pwm, m_pe, m_pend});
         end
      end
      vectors++;
      if (hi0 !== 14) begin miscompares++; $display("FAIL pol_ch0_high: got %0d required 14", hi0); end
   endtask
`endif

   initial begin
      test_reset();
      test_run();
      test_glitch_free();
      test_write_on_wrap();
      test_period_change();
      test_extremes();
      test_reset_mid();
      test_random();
`ifdef SERVO_PWM_POLARITY_EN
      test_polarity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
